// File: rtl/fifo_param_sync.sv
// Purpose  : parametrised single-clock FIFO with occupancy count, threshold flags and registered status pulses.
// Latency  : one cycle from an accepted read to data_out; a written word is readable the cycle after its write.
// Backpres.: a write while full is dropped and flagged by overflow; a read while empty is dropped and flagged by underflow.
//
// Ports:
//   clk, rst               rising-edge clock; asynchronous active-high reset
//   wr_en, data_in         write request and write data
//   rd_en, data_out        read request and registered read data
//   wr_ack                 the write of the previous cycle was accepted
//   overflow/underflow     the write/read of the previous cycle was rejected
//   full, empty            count == DEPTH / count == 0
//   almostfull             ALMOST_FULL_TH <= count < DEPTH
//   almostempty            0 < count <= ALMOST_EMPTY_TH
//   count                  current occupancy
module fifo_param_sync #(
    parameter int DATA_WIDTH      = 16,
    parameter int DEPTH           = 8,
    parameter int ALMOST_FULL_TH  = 7,
    parameter int ALMOST_EMPTY_TH = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic                         rd_en,
    input  logic [DATA_WIDTH-1:0]        data_in,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         wr_ack,
    output logic                         overflow,
    output logic                         underflow,
    output logic                         full,
    output logic                         empty,
    output logic                         almostfull,
    output logic                         almostempty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AF    = CNT_W'(ALMOST_FULL_TH);
    localparam logic [CNT_W-1:0] CNT_AE    = CNT_W'(ALMOST_EMPTY_TH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;

    // Status flags are pure decodes of the occupancy counter.
    assign full        = (count == CNT_DEPTH);
    assign empty       = (count == '0);
    assign almostfull  = (count >= CNT_AF) && (count < CNT_DEPTH);
    assign almostempty = (count != '0) && (count <= CNT_AE);

    // When full, a simultaneous read still proceeds but the write is refused;
    // when empty, the write proceeds and the read is refused.
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_out  <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ack    <= wr_acc;
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;

            // Explicit wrap compare keeps non-power-of-two depths correct.
            if (wr_acc) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (rd_acc) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
            end

            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
